// File: rtl/register_file_2r1w.sv
// Two-read, one-write register file with registered read ports, write-first bypass
// and a sequenced bulk-clear engine. Define REGFILE_ZERO_REG_EN to hard-wire entry 0 to zero.
module register_file_2r1w #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wAddr,
    input  logic [DATA_WIDTH-1:0] wData,
    input  logic                  re0,
    input  logic [ADDR_WIDTH-1:0] rAddr0,
    output logic [DATA_WIDTH-1:0] rData0,
    output logic                  rValid0,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] rAddr1,
    output logic [DATA_WIDTH-1:0] rData1,
    output logic                  rValid1,
    input  logic                  clear,
    output logic                  busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
`ifdef REGFILE_ZERO_REG_EN
    localparam int unsigned FIRST = 1;
`else
    localparam int unsigned FIRST = 0;
`endif

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [FIRST:DEPTH-1];
    logic                    idle;
    logic                    wr_en;

    assign idle  = (state == IDLE);
    assign busy  = (state == CLEAR);
    assign wr_en = idle && we && !clear;

    // Mux-style lookup keeps address 0 in range when entry 0 has no storage.
    function automatic logic [DATA_WIDTH-1:0] read_entry(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = FIRST; i < DEPTH; i++) begin
            if (a == ADDR_WIDTH'(i)) v = mem[i];
        end
        return v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] port_data(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] v;
        v = (we && (wAddr == a)) ? wData : read_entry(a);
`ifdef REGFILE_ZERO_REG_EN
        if (a == '0) v = '0;
`endif
        return v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (clear) state_next = CLEAR;
            CLEAR:   if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)             clr_cnt <= '0;
        else if (state == CLEAR)  clr_cnt <= clr_cnt + 1'b1;
        else                      clr_cnt <= '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = FIRST; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int unsigned i = FIRST; i < DEPTH; i++) begin
                if (state == CLEAR) begin
                    if (clr_cnt == ADDR_WIDTH'(i)) mem[i] <= '0;
                end else if (wr_en && (wAddr == ADDR_WIDTH'(i))) begin
                    mem[i] <= wData;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rData0  <= '0;
            rValid0 <= 1'b0;
            rData1  <= '0;
            rValid1 <= 1'b0;
        end else begin
            rValid0 <= idle && re0;
            rValid1 <= idle && re1;
            if (idle && re0) rData0 <= port_data(rAddr0);
            if (idle && re1) rData1 <= port_data(rAddr1);
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Randomized and directed bench for register_file_2r1w against an array-based reference model.
// Compile with REGFILE_ZERO_REG_EN to exercise the hard-wired zero entry.
module tb_register_file_2r1w;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          we, re0, re1, clear;
    logic [AW-1:0] wAddr, rAddr0, rAddr1;
    logic [DW-1:0] wData;
    logic [DW-1:0] rData0, rData1;
    logic          rValid0, rValid1, busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_d0, exp_d1;
    logic          exp_v0, exp_v1;
    int            busy_left;

    register_file_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .we(we), .wAddr(wAddr), .wData(wData),
        .re0(re0), .rAddr0(rAddr0), .rData0(rData0), .rValid0(rValid0),
        .re1(re1), .rAddr1(rAddr1), .rData1(rData1), .rValid1(rValid1),
        .clear(clear), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
        if (a == 0) return '0;
`endif
        if (we && wAddr == a) return wData;
        return model_mem[a];
    endfunction

    task automatic model_reset();
        foreach (model_mem[i]) model_mem[i] = '0;
        exp_d0 = '0; exp_d1 = '0; exp_v0 = 0; exp_v1 = 0; busy_left = 0;
    endtask

    task automatic idle_inputs();
        we = 0; re0 = 0; re1 = 0; clear = 0;
        wAddr = '0; rAddr0 = '0; rAddr1 = '0; wData = '0;
    endtask

    // Advance the model with the current inputs, then one clock edge; sample 1ns later.
    task automatic tick();
        if (busy_left == 0) begin
            exp_v0 = re0;
            exp_v1 = re1;
            if (re0) exp_d0 = model_read(rAddr0);
            if (re1) exp_d1 = model_read(rAddr1);
            if (clear) begin
                foreach (model_mem[i]) model_mem[i] = '0;
                busy_left = DEPTH;
            end else if (we) begin
`ifdef REGFILE_ZERO_REG_EN
                if (wAddr != 0) model_mem[wAddr] = wData;
`else
                model_mem[wAddr] = wData;
`endif
            end
        end else begin
            exp_v0 = 0; exp_v1 = 0;
            busy_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_inputs();
        we = 1; wAddr = a; wData = d;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        model_reset();
        #12;
        n_total++;
        if ({rData0, rData1, rValid0, rValid1, busy} !== '0)
            $display("FAIL reset_outputs: got d0=%h d1=%h v0=%b v1=%b busy=%b, want all 0",
                     rData0, rData1, rValid0, rValid1, busy);
        else n_pass++;
        @(negedge clk);
        reset_n = 1;
        re0 = 1; rAddr0 = 3'd5;
        tick();
        n_total++;
        if (rData0 !== 32'h0 || rValid0 !== 1'b1)
            $display("FAIL reset_read: got d0=%h v0=%b, want 00000000 1", rData0, rValid0);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_write_read();
        write_word(3'd3, 32'hDEADBEEF);
        re0 = 1; rAddr0 = 3'd3; re1 = 1; rAddr1 = 3'd3;
        tick();
        n_total++;
        if (rData0 !== 32'hDEADBEEF || rData1 !== 32'hDEADBEEF || rValid0 !== 1 || rValid1 !== 1)
            $display("FAIL write_read: got d0=%h d1=%h v0=%b v1=%b, want deadbeef deadbeef 1 1",
                     rData0, rData1, rValid0, rValid1);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (rValid0 !== 0 || rValid1 !== 0 || rData0 !== 32'hDEADBEEF || rData1 !== 32'hDEADBEEF)
            $display("FAIL valid_pulse: got v0=%b v1=%b d0=%h d1=%h, want 0 0 deadbeef deadbeef",
                     rValid0, rValid1, rData0, rData1);
        else n_pass++;
    endtask

    task automatic test_bypass();
        write_word(3'd6, 32'hAAAA0000);
        write_word(3'd2, 32'h22222222);
        we = 1; wAddr = 3'd6; wData = 32'h12345678;
        re1 = 1; rAddr1 = 3'd6; re0 = 1; rAddr0 = 3'd2;
        tick();
        n_total++;
        if (rData1 !== 32'h12345678 || rData0 !== 32'h22222222)
            $display("FAIL bypass: got d1=%h d0=%h, want 12345678 22222222", rData1, rData0);
        else n_pass++;
        we = 1; wAddr = 3'd4; wData = 32'h0BADF00D;
        re0 = 1; rAddr0 = 3'd4; re1 = 1; rAddr1 = 3'd4;
        tick();
        n_total++;
        if (rData0 !== 32'h0BADF00D || rData1 !== 32'h0BADF00D)
            $display("FAIL dual_bypass: got d0=%h d1=%h, want 0badf00d 0badf00d", rData0, rData1);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_clear();
        int busy_cycles;
        int guard;
        for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 32'h1000_0001 + DW'(i) * 32'h0101_0101);
        clear = 1;
        tick();
        clear = 0;
        busy_cycles = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            busy_cycles++;
            guard++;
            we = 1; wAddr = 3'd1; wData = 32'hFFFFFFFF; re0 = 1; rAddr0 = 3'd1; clear = 1;
            tick();
            n_total++;
            if (rValid0 !== 1'b0)
                $display("FAIL busy_read_ignored: got v0=%b, want 0", rValid0);
            else n_pass++;
        end
        idle_inputs();
        n_total++;
        if (busy_cycles != DEPTH)
            $display("FAIL busy_length: got %0d cycles, want %0d", busy_cycles, DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            re0 = 1; rAddr0 = AW'(i); re1 = 1; rAddr1 = AW'(DEPTH - 1 - i);
            tick();
            n_total++;
            if (rData0 !== 32'h0 || rData1 !== 32'h0 || rValid0 !== 1 || rValid1 !== 1)
                $display("FAIL post_clear_read[%0d]: got d0=%h d1=%h v0=%b v1=%b, want 0 0 1 1",
                         i, rData0, rData1, rValid0, rValid1);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 32'h5A5A_0000 | DW'(i));
        re0 = 1; rAddr0 = 3'd7;
        tick();
        idle_inputs();
        clear = 1;
        tick();
        clear = 0;
        tick();
        tick();
        n_total++;
        if (busy !== 1'b1) $display("FAIL busy_before_reset: got %b, want 1", busy);
        else n_pass++;
        reset_n = 0;
        model_reset();
        #1;
        n_total++;
        if ({rData0, rData1, rValid0, rValid1, busy} !== '0)
            $display("FAIL async_reset: got d0=%h d1=%h v0=%b v1=%b busy=%b, want all 0",
                     rData0, rData1, rValid0, rValid1, busy);
        else n_pass++;
        @(negedge clk);
        reset_n = 1;
        tick();
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL busy_after_reset: got %b, want 0", busy);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            re0 = 1; rAddr0 = AW'(i);
            tick();
            n_total++;
            if (rData0 !== 32'h0 || rValid0 !== 1'b1)
                $display("FAIL reset_clear_read[%0d]: got d0=%h v0=%b, want 0 1", i, rData0, rValid0);
            else n_pass++;
        end
        idle_inputs();
    endtask

`ifdef REGFILE_ZERO_REG_EN
    task automatic test_zero_reg();
        we = 1; wAddr = 3'd0; wData = 32'hCAFEF00D; re0 = 1; rAddr0 = 3'd0;
        tick();
        n_total++;
        if (rData0 !== 32'h0) $display("FAIL zero_bypass: got %h, want 00000000", rData0);
        else n_pass++;
        idle_inputs();
        re0 = 1; rAddr0 = 3'd0;
        tick();
        n_total++;
        if (rData0 !== 32'h0) $display("FAIL zero_read: got %h, want 00000000", rData0);
        else n_pass++;
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we     = $urandom_range(0, 1);
            wAddr  = AW'($urandom_range(0, DEPTH - 1));
            wData  = $urandom;
            re0    = $urandom_range(0, 3) != 0;
            rAddr0 = AW'($urandom_range(0, DEPTH - 1));
            re1    = $urandom_range(0, 3) != 0;
            rAddr1 = ($urandom_range(0, 3) == 0) ? wAddr : AW'($urandom_range(0, DEPTH - 1));
            clear  = $urandom_range(0, 39) == 0;
            tick();
            n_total++;
            if (rValid0 !== exp_v0 || rValid1 !== exp_v1 || rData0 !== exp_d0 ||
                rData1 !== exp_d1 || busy !== (busy_left > 0))
                $display("FAIL random[%0d]: got d0=%h v0=%b d1=%h v1=%b busy=%b, want d0=%h v0=%b d1=%h v1=%b busy=%b",
                         c, rData0, rValid0, rData1, rValid1, busy,
                         exp_d0, exp_v0, exp_d1, exp_v1, busy_left > 0);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
`ifdef REGFILE_ZERO_REG_EN
        test_zero_reg();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
